// File: rtl/stim_sweep_capture.sv
// stim_sweep_capture
//   Drives every N_IN-bit vector into a benchmark DUT, samples its single-bit
//   response after a settle window, and queues {vector,response} records in a
//   first-word-fall-through FIFO for a logger while folding them into a MISR.
module stim_sweep_capture #(
  parameter int                N_IN       = 3,
  parameter int                SETTLE     = 1,
  parameter int                FIFO_DEPTH = 4,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = 16'h8016
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  output logic [N_IN-1:0]   stim_out,
  input  logic              dut_out,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [N_IN-1:0]   rec_vec,
  output logic              rec_bit,
  output logic              busy,
  output logic              done,
  output logic [MISR_W-1:0] signature
);

  localparam int REC_W = N_IN + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_STALL  = 3'd4,
    S_FLUSH  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // One MISR step: shift, conditional polynomial feedback, fold in the record.
  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig,
                                                  input logic [REC_W-1:0]  rec);
    logic [MISR_W-1:0] fb;
    fb = sig[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}};
    return (sig << 1) ^ fb ^ MISR_W'(rec);
  endfunction

  // Sequencer state
  state_t            state_q;
  logic [N_IN-1:0]   pattern_q;
  logic [N_IN-1:0]   stim_q;
  logic [SET_W-1:0]  cnt_q;
  logic [MISR_W-1:0] sig_q;
  logic              busy_q;
  logic              done_q;

  // Record FIFO state
  logic [REC_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              valid_q;

  // Next-state / handshake signals
  logic              pop_s;
  logic              full_s;
  logic              push_s;
  logic [REC_W-1:0]  rec_s;
  logic [MISR_W-1:0] sig_d;
  logic [PTR_W-1:0]  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_d;
  logic [CNT_W-1:0]  count_d;

  // FIFO handshake decode; "full" already credits a pop in the same cycle.
  always_comb begin
    pop_s  = valid_q && rec_ready;
    full_s = (count_q == CNT_W'(FIFO_DEPTH)) && !pop_s;
    push_s = (state_q == S_SAMPLE) && !full_s;
    rec_s  = {pattern_q, dut_out};
    sig_d  = misr_next(sig_q, rec_s);

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Record FIFO storage, pointers and registered head-valid flag.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {REC_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= rec_s;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != {CNT_W{1'b0}});
    end
  end

  // Sweep sequencer: drive, settle, sample/stall, then flush to done.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pattern_q <= {N_IN{1'b0}};
      stim_q    <= {N_IN{1'b0}};
      cnt_q     <= {SET_W{1'b0}};
      sig_q     <= {MISR_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            pattern_q <= {N_IN{1'b0}};
            sig_q     <= {MISR_W{1'b0}};
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_DRIVE;
          end else begin
            state_q   <= state_q;
          end
        end
        S_DRIVE: begin
          stim_q  <= pattern_q;
          cnt_q   <= SET_W'(SETTLE - 1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q != {SET_W{1'b0}}) begin
            cnt_q <= cnt_q - SET_W'(1'b1);
          end else begin
            state_q <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (full_s) begin
            // No room even after this cycle's pop: hold the vector and retry.
            state_q <= S_STALL;
          end else begin
            sig_q <= sig_d;
            if (pattern_q == {N_IN{1'b1}}) begin
              state_q <= S_FLUSH;
            end else begin
              pattern_q <= pattern_q + N_IN'(1'b1);
              state_q   <= S_DRIVE;
            end
          end
        end
        S_STALL: begin
          if (!full_s) begin
            state_q <= S_SAMPLE;
          end else begin
            state_q <= S_STALL;
          end
        end
        S_FLUSH: begin
          if (count_q == {CNT_W{1'b0}}) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_FLUSH;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign stim_out  = stim_q;
  assign rec_valid = valid_q;
  assign rec_vec   = mem_q[rd_ptr_q][REC_W-1:1];
  assign rec_bit   = mem_q[rd_ptr_q][0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_stim_sweep_capture.sv
// Bench for stim_sweep_capture: two instances (SETTLE=1 with a combinational
// stub DUT, SETTLE=3 with a registered N[0] stub), randomized logger
// backpressure, records and signatures checked against a behavioural model.
`timescale 1ns/1ps
module tb_stim_sweep_capture;

  localparam int NV = 8;

  logic        CK;
  logic        reset;
  logic        start;
  logic        rec_ready;
  logic        sel;
  logic [1:0]  mode;
  logic [7:0]  tt;

  int checks;
  int errors;

  // Instance A (SETTLE=1)
  logic        start_a, dut_a, valid_a, bit_a, busy_a, done_a;
  logic [2:0]  stim_a, vec_a;
  logic [15:0] sig_a;
  // Instance B (SETTLE=3)
  logic        start_b, dut_b, valid_b, bit_b, busy_b, done_b;
  logic [2:0]  stim_b, vec_b;
  logic [15:0] sig_b;
  // Selected view
  logic        v_valid, v_bit, v_busy, v_done;
  logic [2:0]  v_stim, v_vec;
  logic [15:0] v_sig;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  assign v_valid = sel ? valid_b : valid_a;
  assign v_bit   = sel ? bit_b   : bit_a;
  assign v_busy  = sel ? busy_b  : busy_a;
  assign v_done  = sel ? done_b  : done_a;
  assign v_stim  = sel ? stim_b  : stim_a;
  assign v_vec   = sel ? vec_b   : vec_a;
  assign v_sig   = sel ? sig_b   : sig_a;

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Stub DUT A: XOR of inputs, constant 0, or a truth table.
  always_comb begin
    case (mode)
      2'd0:    dut_a = ^stim_a;
      2'd1:    dut_a = 1'b0;
      default: dut_a = tt[stim_a];
    endcase
  end

  // Stub DUT B: registered copy of N[0].
  always_ff @(posedge CK) dut_b <= stim_b[0];

  stim_sweep_capture #(.N_IN(3), .SETTLE(1), .FIFO_DEPTH(4), .MISR_W(16), .MISR_POLY(16'h8016)) u_dut (
    .CK(CK), .reset(reset), .start(start_a), .stim_out(stim_a), .dut_out(dut_a),
    .rec_valid(valid_a), .rec_ready(rec_ready), .rec_vec(vec_a), .rec_bit(bit_a),
    .busy(busy_a), .done(done_a), .signature(sig_a));

  stim_sweep_capture #(.N_IN(3), .SETTLE(3), .FIFO_DEPTH(4), .MISR_W(16), .MISR_POLY(16'h8016)) u_dut3 (
    .CK(CK), .reset(reset), .start(start_b), .stim_out(stim_b), .dut_out(dut_b),
    .rec_valid(valid_b), .rec_ready(rec_ready), .rec_vec(vec_b), .rec_bit(bit_b),
    .busy(busy_b), .done(done_b), .signature(sig_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected response of the stub DUT for vector v.
  function automatic logic exp_bit(input bit ib, input logic [1:0] md, input logic [7:0] t, input int v);
    if (ib) return (v % 2) == 1;
    case (md)
      2'd0:    return ($countones(v) % 2) == 1;
      2'd1:    return 1'b0;
      default: return t[v];
    endcase
  endfunction

  // Reference signature: integer-arithmetic MISR over records 2*v+bit.
  function automatic logic [15:0] model_sig(input bit ib, input logic [1:0] md, input logic [7:0] t);
    int s;
    s = 0;
    for (int v = 0; v < NV; v++) begin
      int r;
      r = v * 2 + (exp_bit(ib, md, t, v) ? 1 : 0);
      if (s >= 32768) s = ((s * 2) % 65536) ^ 32'h8016;
      else            s = (s * 2) % 65536;
      s = s ^ r;
    end
    return 16'(s);
  endfunction

  // One complete sweep; called at posedge+1, returns at posedge+1.
  task automatic run_sweep(input bit ib, input logic [1:0] md, input logic [7:0] t,
                           input int hold, input int pct, input int extra_start,
                           output logic [15:0] sig_out);
    int got;
    bit pend;
    bit finished;
    logic [2:0] hv;
    logic hb;
    logic [15:0] exp_sig;
    sel = ib; mode = md; tt = t;
    got = 0; pend = 1'b0; finished = 1'b0; hv = 3'd0; hb = 1'b0;
    exp_sig = model_sig(ib, md, t);
    for (int c = 0; c < 600; c++) begin
      start = (c == 0) || (c == extra_start);
      if (c < hold) rec_ready = 1'b0;
      else          rec_ready = (int'($urandom_range(99)) < pct);
      @(negedge CK);
      if (hold > 0 && c == hold - 1) begin
        chk("stall_stim", 32'(v_stim), 32'd4);
        chk("stall_valid", 32'(v_valid), 32'd1);
        chk("stall_head", 32'(v_vec), 32'd0);
        chk("stall_busy", 32'(v_busy), 32'd1);
      end
      if (pend && v_valid) begin
        chk("head_vec_hold", 32'(v_vec), 32'(hv));
        chk("head_bit_hold", 32'(v_bit), 32'(hb));
      end
      pend = v_valid && !rec_ready;
      hv = v_vec;
      hb = v_bit;
      if (v_valid && rec_ready) begin
        if (got < NV) begin
          chk("rec_vec", 32'(v_vec), 32'(got));
          chk("rec_bit", 32'(v_bit), 32'(exp_bit(ib, md, t, got)));
        end else begin
          chk("extra_rec", 32'(v_valid), 32'd0);
        end
        got++;
      end
      if (v_done && got >= NV && c > 0) begin
        finished = 1'b1;
        break;
      end
      @(posedge CK); #1;
    end
    @(posedge CK); #1;
    start = 1'b0;
    rec_ready = 1'b0;
    chk("sweep_finished", 32'(finished), 32'd1);
    chk("rec_count", 32'(got), 32'(NV));
    chk("busy_end", 32'(v_busy), 32'd0);
    chk("signature", 32'(v_sig), 32'(exp_sig));
    repeat (3) @(posedge CK);
    #1;
    chk("sig_stable", 32'(v_sig), 32'(exp_sig));
    chk("done_held", 32'(v_done), 32'd1);
    chk("stim_last", 32'(v_stim), 32'd7);
    sig_out = v_sig;
  endtask

  // Time bound for the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  logic [15:0] sig_xor, sig_zero, sig_r1, sig_r2, sig_tmp;

  // Directed sequence of sweeps with randomized backpressure.
  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; start = 1'b0; rec_ready = 1'b0;
    sel = 1'b0; mode = 2'd0; tt = 8'd0;
    repeat (3) @(posedge CK);
    #1;
    chk("rst_stim", 32'(stim_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_sig", 32'(sig_a), 32'd0);
    reset = 1'b1;
    @(posedge CK); #1;

    // XOR DUT, logger always ready
    run_sweep(1'b0, 2'd0, 8'd0, 0, 100, -1, sig_xor);
    // Logger stalled 30 cycles: FIFO fills, sequencer stalls on vector 4
    run_sweep(1'b0, 2'd0, 8'd0, 30, 100, -1, sig_tmp);
    // Start pulsed mid-sweep is ignored; a second sweep reproduces the signature
    run_sweep(1'b0, 2'd0, 8'd0, 0, 100, 5, sig_r1);
    run_sweep(1'b0, 2'd0, 8'd0, 0, 60, -1, sig_r2);
    chk("resweep_sig", 32'(sig_r2), 32'(sig_r1));
    // Constant-0 DUT gives a different signature
    run_sweep(1'b0, 2'd1, 8'd0, 0, 100, -1, sig_zero);
    chk("sig_differ", 32'(sig_zero != sig_xor), 32'd1);
    // Random truth tables with random backpressure
    for (int k = 0; k < 3; k++) begin
      run_sweep(1'b0, 2'd2, 8'($urandom), 0, int'($urandom_range(30, 90)), -1, sig_tmp);
    end
    // SETTLE=3 with a one-cycle-lag DUT
    run_sweep(1'b1, 2'd0, 8'd0, 0, 100, -1, sig_tmp);
    run_sweep(1'b1, 2'd0, 8'd0, 0, 40, -1, sig_tmp);

    // Reset in the middle of a sweep
    sel = 1'b0; mode = 2'd0;
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    repeat (9) @(posedge CK);
    #1;
    chk("mid_busy", 32'(busy_a), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_stim", 32'(stim_a), 32'd0);
    chk("arst_valid", 32'(valid_a), 32'd0);
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_done", 32'(done_a), 32'd0);
    chk("arst_sig", 32'(sig_a), 32'd0);
    repeat (2) @(posedge CK);
    #1;
    reset = 1'b1;
    @(posedge CK); #1;
    run_sweep(1'b0, 2'd0, 8'd0, 0, 100, -1, sig_tmp);
    chk("post_reset_sig", 32'(sig_tmp), 32'(sig_xor));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
